// File: rtl/gtech_pad_pkg.sv
// Shared definitions for the pad-side serial transmit controller:
// FSM state encoding, the pad levels driven in each phase, and the
// helper that sizes the shared phase counter.
package gtech_pad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TURN  = 2'd3
    } pad_state_e;

    localparam logic LEAD_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b0;

    // Counter must hold the largest preload of any phase (value-1), so
    // clog2(max+1) bits cover every phase length with room to spare.
    function automatic int cnt_width(input int w, input int l, input int t);
        int m;
        m = w;
        if (l > m) m = l;
        if (t > m) m = t;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gtech_outbuf_ser_if.sv
// Word-level valid/ready transmit handshake feeding the serializer.
interface gtech_outbuf_ser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] TX_DATA;
    logic             TX_VALID;
    logic             TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/gtech_pad_cnt.sv
// Loadable synchronous down-counter with a zero flag; one instance is
// shared across the lead-in, shift and turnaround phases.
module gtech_pad_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; reset returns the count to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gtech_outbuf_ser.sv
// Parallel-to-serial transmitter driving a tristate pad buffer. Each
// accepted word goes out MSB-first framed by a driven-high lead-in and an
// undriven turnaround. All pad-facing outputs are flops fed from the
// next-state decode, so OE cannot glitch.
module gtech_outbuf_ser
    import gtech_pad_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEAD  = 2,
    parameter int TURN  = 1
) (
    input  logic                CP,
    input  logic                RST,
    gtech_outbuf_ser_if.slave   tx,
    output logic                DATA_OUT,
    output logic                OE,
    output logic                BUSY
);

    localparam int CNT_W = cnt_width(WIDTH, LEAD, TURN);

    pad_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             data_out_q, data_out_d;
    logic             oe_q, oe_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;

    gtech_pad_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (CP),
        .rst        (RST),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_value),
        .zero_o     (cnt_zero)
    );

    // Next-state, shift-register and counter control, then the Moore
    // outputs decoded from the state being entered so they can be
    // registered alongside it.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        data_out_d = IDLE_LEVEL;
        oe_d       = 1'b0;
        ready_d    = 1'b0;
        busy_d     = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (tx.TX_VALID && ready_q) begin
                    sr_d     = tx.TX_DATA;
                    cnt_load = 1'b1;
                    if (LEAD > 0) begin
                        state_d = ST_LEAD;
                        cnt_val = CNT_W'(LEAD - 1);
                    end else begin
                        state_d = ST_SHIFT;
                        cnt_val = CNT_W'(WIDTH - 1);
                    end
                end
            end
            ST_LEAD: begin
                if (cnt_zero) begin
                    state_d  = ST_SHIFT;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(WIDTH - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SHIFT: begin
                sr_d = sr_q << 1;
                if (cnt_zero) begin
                    if (TURN > 0) begin
                        state_d  = ST_TURN;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(TURN - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_LEAD: begin
                oe_d       = 1'b1;
                data_out_d = LEAD_LEVEL;
            end
            ST_SHIFT: begin
                oe_d       = 1'b1;
                data_out_d = sr_d[WIDTH-1];
            end
            default: begin
                data_out_d = IDLE_LEVEL;
            end
        endcase
    end

    // State, shift register and registered pad outputs; reset abandons
    // any partial frame and overrides a coincident handshake.
    always_ff @(posedge CP) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            data_out_q <= IDLE_LEVEL;
            oe_q       <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx.TX_READY = ready_q;
    assign DATA_OUT    = data_out_q;
    assign OE          = oe_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_gtech_outbuf_ser.sv
// Directed scoreboard bench: two instances (LEAD=2/TURN=1 and
// LEAD=0/TURN=0). Every driven cycle updates an expected-output queue
// built from the frame timing; every cycle pops one entry and compares
// {OE, DATA_OUT, TX_READY, BUSY}.
module tb_gtech_outbuf_ser;

    logic CP  = 1'b0;
    logic RST = 1'b1;

    logic data0, oe0, busy0;
    logic data1, oe1, busy1;

    int checks   = 0;
    int failures = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic       lastReady0 = 1'b1;
    logic       lastReady1 = 1'b1;

    localparam logic [3:0] EXP_IDLE = 4'b0010;

    gtech_outbuf_ser_if #(.WIDTH(8)) tx0 ();
    gtech_outbuf_ser_if #(.WIDTH(8)) tx1 ();

    gtech_outbuf_ser #(.WIDTH(8), .LEAD(2), .TURN(1)) dut0 (
        .CP       (CP),
        .RST      (RST),
        .tx       (tx0.slave),
        .DATA_OUT (data0),
        .OE       (oe0),
        .BUSY     (busy0)
    );

    gtech_outbuf_ser #(.WIDTH(8), .LEAD(0), .TURN(0)) dut1 (
        .CP       (CP),
        .RST      (RST),
        .tx       (tx1.slave),
        .DATA_OUT (data1),
        .OE       (oe1),
        .BUSY     (busy1)
    );

    always #5 CP = ~CP;

    // Expected per-cycle outputs of one frame: lead-in, MSB-first bits,
    // turnaround. The idle cycle afterwards is implied by an empty queue.
    task automatic pushFrame(input int dut, input logic [7:0] word);
        int lead;
        int turn;
        lead = (dut == 0) ? 2 : 0;
        turn = (dut == 0) ? 1 : 0;
        for (int i = 0; i < lead; i++) begin
            if (dut == 0) q0.push_back(4'b1101); else q1.push_back(4'b1101);
        end
        for (int k = 7; k >= 0; k--) begin
            if (dut == 0) q0.push_back({1'b1, word[k], 2'b01});
            else          q1.push_back({1'b1, word[k], 2'b01});
        end
        for (int i = 0; i < turn; i++) begin
            if (dut == 0) q0.push_back(4'b0001); else q1.push_back(4'b0001);
        end
    endtask

    // One clock: drive inputs, record any expected handshake, then sample
    // 1 time unit after the edge and compare against the scoreboard.
    task automatic tick(input int dut, input logic v, input logic [7:0] d,
                        input logic r, input string tag);
        logic [3:0] expv;
        logic [3:0] obs;
        RST = r;
        if (dut == 0) begin
            tx0.TX_VALID = v; tx0.TX_DATA = d;
            tx1.TX_VALID = 1'b0; tx1.TX_DATA = 8'h00;
        end else begin
            tx1.TX_VALID = v; tx1.TX_DATA = d;
            tx0.TX_VALID = 1'b0; tx0.TX_DATA = 8'h00;
        end
        if (r) begin
            q0.delete();
            q1.delete();
        end else if (v && dut == 0 && lastReady0) begin
            pushFrame(0, d);
        end else if (v && dut == 1 && lastReady1) begin
            pushFrame(1, d);
        end
        @(posedge CP);
        #1;
        if (r) begin
            lastReady0 = 1'b1;
            lastReady1 = 1'b1;
        end
        if (dut == 0) begin
            expv = (q0.size() > 0) ? q0.pop_front() : EXP_IDLE;
            obs  = {oe0, data0, tx0.TX_READY, busy0};
            lastReady0 = expv[1];
        end else begin
            expv = (q1.size() > 0) ? q1.pop_front() : EXP_IDLE;
            obs  = {oe1, data1, tx1.TX_READY, busy1};
            lastReady1 = expv[1];
        end
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s @%0t: {OE,DATA,RDY,BUSY} got=%b expected=%b",
                   tag, $time, obs, expv);
        end
    endtask

    initial begin
        tx0.TX_VALID = 1'b0; tx0.TX_DATA = 8'h00;
        tx1.TX_VALID = 1'b0; tx1.TX_DATA = 8'h00;

        // Reset held 3 cycles with TX_VALID high: no handshake, idle outputs.
        for (int i = 0; i < 3; i++) tick(0, 1'b1, 8'h5A, 1'b1, "reset");
        tick(0, 1'b0, 8'h00, 1'b0, "post_reset_idle");

        // Single frame 0xA5 plus trailing idle cycles.
        tick(0, 1'b1, 8'hA5, 1'b0, "a5_handshake");
        for (int i = 0; i < 12; i++) tick(0, 1'b0, 8'h00, 1'b0, "a5_frame");

        // Back-to-back 0x3C then 0xC3 with TX_VALID held.
        for (int i = 0; i < 12; i++) tick(0, 1'b1, 8'h3C, 1'b0, "b2b_3c");
        for (int i = 0; i < 12; i++) tick(0, 1'b1, 8'hC3, 1'b0, "b2b_c3");
        tick(0, 1'b0, 8'h00, 1'b0, "b2b_tail");

        // Reset mid-frame of 0xFF, then 0x81 with a full lead-in.
        tick(0, 1'b1, 8'hFF, 1'b0, "ff_handshake");
        for (int i = 0; i < 6; i++) tick(0, 1'b0, 8'h00, 1'b0, "ff_partial");
        tick(0, 1'b0, 8'h00, 1'b1, "ff_abort_reset");
        tick(0, 1'b1, 8'h81, 1'b0, "r81_handshake");
        for (int i = 0; i < 12; i++) tick(0, 1'b0, 8'h00, 1'b0, "r81_frame");

        // LEAD=0, TURN=0 instance: 0x01 then 0x80 with TX_VALID held.
        tick(1, 1'b0, 8'h00, 1'b0, "nl_idle");
        for (int i = 0; i < 9; i++) tick(1, 1'b1, 8'h01, 1'b0, "nl_01");
        for (int i = 0; i < 9; i++) tick(1, 1'b1, 8'h80, 1'b0, "nl_80");
        tick(1, 1'b0, 8'h00, 1'b0, "nl_tail");

        // TX_VALID pulsed and TX_DATA toggled throughout a frame.
        tick(0, 1'b1, 8'h96, 1'b0, "tog_handshake");
        for (int i = 0; i < 40 && q0.size() > 0; i++)
            tick(0, 1'(i % 2), 8'($urandom_range(0, 255)), 1'b0, "tog_frame");
        tick(0, 1'b0, 8'h00, 1'b0, "tog_tail");
        tick(0, 1'b0, 8'h00, 1'b0, "tog_tail2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
